uart_rx_framed: RTL and testbench

Parametrised UART receiver, successor to the fixed 8N1 receiver.
- Configurable data bits, parity mode and stop bits.
- Majority-vote sampling at bit centre.
- False-start rejection.
- Parity, framing and overrun error reporting.
- Valid/ready output handshake, so a consumer (FIFO, bus bridge, command parser) can stall without losing the held word.

---
 rtl/uart_rx_framed_pkg.sv | 31 +++
 rtl/uart_rx_framed_sampler.sv | 45 ++++
 rtl/uart_rx_framed.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_rx_framed.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_framed_pkg.sv
// uart_rx_framed_pkg
//    Shared definitions for the framed UART receiver: parity mode
//    encodings, receiver state encoding, the cycles-per-bit computation
//    and the three-sample majority helper used by the line sampler.
//    No ports; imported by uart_rx_framed and uart_rx_framed_sampler.

package uart_rx_framed_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4
   } rxState_e;

   // Integer division on purpose: the bit period is rounded down, and the
   // counter only ever needs to reach the centre of each bit.
   function automatic int cyclesPerBit(input int clockHz, input int baud);
      return clockHz / baud;
   endfunction

   function automatic logic majority3(input logic [2:0] samples);
      return (samples[0] & samples[1]) | (samples[0] & samples[2]) | (samples[1] & samples[2]);
   endfunction

endpackage

// File: rtl/uart_rx_framed_sampler.sv
// uart_rx_framed_sampler
//    Line conditioning for one serial input: two-flop synchroniser, falling
//    edge detector and a three-sample majority vote.
//    Ports:
//       clock       system clock
//       reset_n     asynchronous active-low reset
//       rx_i        raw asynchronous serial line (idle high)
//       fallEdge_o  synchronised line went 1 -> 0 this cycle
//       bitValue_o  majority of the last three synchronised samples

module uart_rx_framed_sampler
   import uart_rx_framed_pkg::*;
(
   input  logic clock,
   input  logic reset_n,
   input  logic rx_i,
   output logic fallEdge_o,
   output logic bitValue_o
);

   logic [1:0] sync_q;
   logic       prev_q;
   logic [2:0] vote_q;

   // Everything resets to the idle-line level so that reset release does
   // not look like a start edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= 2'b11;
         prev_q <= 1'b1;
         vote_q <= 3'b111;
      end else begin
         sync_q <= {sync_q[0], rx_i};
         prev_q <= sync_q[1];
         vote_q <= {vote_q[1:0], sync_q[1]};
      end
   end

   // Edge and vote are combinational views of the registered history.
   always_comb begin
      fallEdge_o = prev_q & ~sync_q[1];
      bitValue_o = majority3(vote_q);
   end

endmodule

// File: rtl/uart_rx_framed.sv
// uart_rx_framed
//    Parametrised UART receiver: configurable data bits, parity and stop
//    bits, majority-vote sampling at bit centre, false-start rejection,
//    parity/framing/overrun reporting and a valid/ready output handshake.
//    Ports:
//       clock          system clock, rising edge
//       reset_n        asynchronous active-low reset
//       rx             serial line, idle high
//       data           received word, LSB first on the line
//       data_valid     data and error flags valid, held until accepted
//       data_ready     consumer accepts when data_valid & data_ready
//       parity_error   parity mismatch for the held word
//       framing_error  a stop bit was sampled low for the held word
//       overrun        sticky: a frame completed while a word was still held
//       busy           receiver is mid-frame

module uart_rx_framed
   import uart_rx_framed_pkg::*;
#(
   parameter int clock_frequency = 50000000,
   parameter int baud_rate       = 115200,
   parameter int data_bits       = 8,
   parameter int parity_mode     = 0,
   parameter int stop_bits       = 1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 rx,
   output logic [data_bits-1:0] data,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 parity_error,
   output logic                 framing_error,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CPB = cyclesPerBit(clock_frequency, baud_rate);
   localparam int CW  = $clog2(CPB * 3 / 2 + 1);
   localparam int IW  = $clog2(data_bits + 1);
   localparam logic [CW-1:0] HALF_BIT = CW'(CPB / 2);
   localparam logic [CW-1:0] FULL_BIT = CW'(CPB);

   logic fallEdge;
   logic bitValue;
   logic tick;
   logic complete;
   logic accept;

   rxState_e             state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [data_bits-1:0] shift_q, shift_d;
   logic [IW-1:0]        bitIdx_q, bitIdx_d;
   logic                 stopIdx_q, stopIdx_d;
   logic                 parErr_q, parErr_d;
   logic                 frameErr_q, frameErr_d;

   logic [data_bits-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 parOut_q, parOut_d;
   logic                 frameOut_q, frameOut_d;
   logic                 overrun_q, overrun_d;

   uart_rx_framed_sampler uSampler (
      .clock      (clock),
      .reset_n    (reset_n),
      .rx_i       (rx),
      .fallEdge_o (fallEdge),
      .bitValue_o (bitValue)
   );

   assign tick = (cnt_q == CW'(1));

   // State register plus the per-frame working registers. An asynchronous
   // reset drops any partial frame immediately.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         shift_q    <= '0;
         bitIdx_q   <= '0;
         stopIdx_q  <= 1'b0;
         parErr_q   <= 1'b0;
         frameErr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         bitIdx_q   <= bitIdx_d;
         stopIdx_q  <= stopIdx_d;
         parErr_q   <= parErr_d;
         frameErr_q <= frameErr_d;
      end
   end

   // Next-state logic. The counter free-runs down to zero and sticks there;
   // each state reloads it on entry, so a tick marks the next bit centre.
   // The start tick lands half a bit after the edge, every later tick one
   // full bit after the previous one.
   always_comb begin
      state_d    = state_q;
      cnt_d      = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
      shift_d    = shift_q;
      bitIdx_d   = bitIdx_q;
      stopIdx_d  = stopIdx_q;
      parErr_d   = parErr_q;
      frameErr_d = frameErr_q;
      complete   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (fallEdge) begin
               state_d = StStart;
               cnt_d   = HALF_BIT;
            end
         end
         StStart: begin
            if (tick) begin
               if (bitValue) begin
                  state_d = StIdle;
               end else begin
                  state_d    = StData;
                  cnt_d      = FULL_BIT;
                  bitIdx_d   = '0;
                  stopIdx_d  = 1'b0;
                  parErr_d   = 1'b0;
                  frameErr_d = 1'b0;
               end
            end
         end
         StData: begin
            if (tick) begin
               shift_d = {bitValue, shift_q[data_bits-1:1]};
               cnt_d   = FULL_BIT;
               if (bitIdx_q == IW'(data_bits - 1)) begin
                  state_d = (parity_mode != PARITY_NONE) ? StParity : StStop;
               end else begin
                  bitIdx_d = bitIdx_q + IW'(1);
               end
            end
         end
         StParity: begin
            // Even parity wants the XOR of data and parity bit to be 0,
            // odd wants 1; folding the mode in gives the error directly.
            if (tick) begin
               parErr_d = (^shift_q) ^ bitValue ^ (parity_mode == PARITY_ODD);
               state_d  = StStop;
               cnt_d    = FULL_BIT;
            end
         end
         StStop: begin
            // Completing straight back into IDLE lets a start edge in the
            // very next cycle be caught.
            if (tick) begin
               if (!bitValue) begin
                  frameErr_d = 1'b1;
               end
               if (stopIdx_q == 1'(stop_bits - 1)) begin
                  complete = 1'b1;
                  state_d  = StIdle;
               end else begin
                  stopIdx_d = 1'b1;
                  cnt_d     = FULL_BIT;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Output holding registers for the delivered word and its flags.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_q     <= '0;
         valid_q    <= 1'b0;
         parOut_q   <= 1'b0;
         frameOut_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         data_q     <= data_d;
         valid_q    <= valid_d;
         parOut_q   <= parOut_d;
         frameOut_q <= frameOut_d;
         overrun_q  <= overrun_d;
      end
   end

   // Handshake: an accept frees the holding register, so a frame completing
   // in the same cycle replaces the word instead of overrunning. If the old
   // word is still held and not accepted, the new frame is dropped.
   always_comb begin
      data_d     = data_q;
      valid_d    = valid_q;
      parOut_d   = parOut_q;
      frameOut_d = frameOut_q;
      overrun_d  = overrun_q;
      accept     = valid_q & data_ready;
      if (accept) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end
      if (complete) begin
         if (!valid_q || data_ready) begin
            data_d     = shift_q;
            parOut_d   = parErr_q;
            frameOut_d = frameErr_d;
            valid_d    = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   // Output decode.
   always_comb begin
      data          = data_q;
      data_valid    = valid_q;
      parity_error  = parOut_q;
      framing_error = frameOut_q;
      overrun       = overrun_q;
      busy          = (state_q != StIdle);
   end

endmodule

// File: tb/tb_uart_rx_framed.sv
// tb_uart_rx_framed
//    Self-checking bench for uart_rx_framed. Three receivers share clock and
//    reset: 8N1, 8E1 and 7O2, all at 16 clocks per bit. Frames are built
//    from the line-protocol rules and every delivered word is compared with
//    what that frame should produce.

module tb_uart_rx_framed;

   localparam int CLK_HZ = 1600000;
   localparam int BAUD   = 100000;
   localparam int CPB    = CLK_HZ / BAUD;

   localparam int DBITS [3] = '{8, 8, 7};
   localparam int PMODE [3] = '{0, 1, 2};
   localparam int SBITS [3] = '{1, 1, 2};

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [2:0] rxLine = 3'b111;
   logic [2:0] readyV = 3'b111;
   logic [7:0] data0;
   logic [7:0] data1;
   logic [6:0] data2;
   logic [2:0] validV, peV, feV, ovV, busyV;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   // Delivered words: [12:11] receiver, [10] framing, [9] parity, [8:0] data.
   logic [12:0] capQ[$];
   logic [2:0]  lastValid  = 3'b000;
   logic [2:0]  lastAccept = 3'b000;

   always #5 clock = ~clock;

   uart_rx_framed #(.clock_frequency(CLK_HZ), .baud_rate(BAUD), .data_bits(8),
                    .parity_mode(0), .stop_bits(1)) dut0 (
      .clock(clock), .reset_n(reset_n), .rx(rxLine[0]), .data(data0),
      .data_valid(validV[0]), .data_ready(readyV[0]), .parity_error(peV[0]),
      .framing_error(feV[0]), .overrun(ovV[0]), .busy(busyV[0]));

   uart_rx_framed #(.clock_frequency(CLK_HZ), .baud_rate(BAUD), .data_bits(8),
                    .parity_mode(1), .stop_bits(1)) dut1 (
      .clock(clock), .reset_n(reset_n), .rx(rxLine[1]), .data(data1),
      .data_valid(validV[1]), .data_ready(readyV[1]), .parity_error(peV[1]),
      .framing_error(feV[1]), .overrun(ovV[1]), .busy(busyV[1]));

   uart_rx_framed #(.clock_frequency(CLK_HZ), .baud_rate(BAUD), .data_bits(7),
                    .parity_mode(2), .stop_bits(2)) dut2 (
      .clock(clock), .reset_n(reset_n), .rx(rxLine[2]), .data(data2),
      .data_valid(validV[2]), .data_ready(readyV[2]), .parity_error(peV[2]),
      .framing_error(feV[2]), .overrun(ovV[2]), .busy(busyV[2]));

   function automatic logic [8:0] dataOf(input int k);
      case (k)
         0:       return {1'b0, data0};
         1:       return {1'b0, data1};
         default: return {2'b00, data2};
      endcase
   endfunction

   function automatic logic [13:0] outputsOf(input int k);
      return {dataOf(k), validV[k], peV[k], feV[k], ovV[k], busyV[k]};
   endfunction

   // Handshake monitor: a new word is on offer when valid rises, or when
   // valid stays high right after an accept (back-to-back delivery).
   always @(negedge clock) begin
      for (int k = 0; k < 3; k++) begin
         if (validV[k] && (!lastValid[k] || lastAccept[k])) begin
            capQ.push_back({2'(k), feV[k], peV[k], dataOf(k)});
         end
         lastValid[k]  = validV[k];
         lastAccept[k] = validV[k] & readyV[k];
      end
   end

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drives one frame onto a receiver's line. The bit list is built from the
   // frame rules: start 0, data LSB first, optional parity (made even or odd,
   // then optionally inverted), then stop bits with optional forced lows.
   // abortAt >= 0 stops half way through that bit position.
   task automatic applyStimulus(input int dut, input logic [8:0] word, input bit flipParity,
                                input logic [1:0] stopLow, input int abortAt);
      bit lineBits[$];
      bit par;
      par = 1'b0;
      lineBits.push_back(1'b0);
      for (int i = 0; i < DBITS[dut]; i++) begin
         lineBits.push_back(word[i]);
         par ^= word[i];
      end
      if (PMODE[dut] != 0) begin
         lineBits.push_back(par ^ (PMODE[dut] == 2) ^ flipParity);
      end
      for (int s = 0; s < SBITS[dut]; s++) begin
         lineBits.push_back(~stopLow[s]);
      end
      foreach (lineBits[b]) begin
         rxLine[dut] = lineBits[b];
         if (b == abortAt) begin
            repeat (CPB / 2) @(negedge clock);
            return;
         end
         repeat (CPB) @(negedge clock);
      end
      rxLine[dut] = 1'b1;
      repeat (2 * CPB) @(negedge clock);
   endtask

   task automatic expectFrame(input string tag, input int dut, input logic [8:0] word,
                              input logic peExp, input logic feExp);
      logic [12:0] rec;
      logic [8:0]  mask;
      for (int c = 0; c < 4 * CPB && capQ.size() == 0; c++) @(negedge clock);
      checkOutput({tag, "_arrived"}, 16'(capQ.size() != 0), 16'd1);
      if (capQ.size() != 0) begin
         rec  = capQ.pop_front();
         mask = 9'((1 << DBITS[dut]) - 1);
         checkOutput({tag, "_data"}, 16'({rec[12:11], rec[8:0]}), 16'({2'(dut), word & mask}));
         checkOutput({tag, "_flags"}, 16'(rec[10:9]), 16'({feExp, peExp}));
      end
   endtask

   // Safety net in case something blocks outside the bounded waits.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence followed by randomized frames on every receiver.
   initial begin
      logic [8:0] word;
      bit         flip;
      logic [1:0] stopLow;
      bit         sawBusy;
      bit         sawValid;

      reset_n = 1'b0;
      repeat (4) @(negedge clock);
      for (int k = 0; k < 3; k++)
         checkOutput($sformatf("reset_outputs_dut%0d", k), 16'(outputsOf(k)), 16'd0);
      reset_n = 1'b1;
      repeat (4) @(negedge clock);

      $display("[TB] 8N1 directed frames");
      applyStimulus(0, 9'h055, 1'b0, 2'b00, -1);
      expectFrame("n81_55", 0, 9'h055, 1'b0, 1'b0);
      applyStimulus(0, 9'h0A3, 1'b0, 2'b00, -1);
      expectFrame("n81_a3", 0, 9'h0A3, 1'b0, 1'b0);

      $display("[TB] 8E1 parity frames");
      applyStimulus(1, 9'h007, 1'b1, 2'b00, -1);
      expectFrame("e81_07_badpar", 1, 9'h007, 1'b1, 1'b0);
      applyStimulus(1, 9'h007, 1'b0, 2'b00, -1);
      expectFrame("e81_07_goodpar", 1, 9'h007, 1'b0, 1'b0);

      $display("[TB] 7O2 framing frame");
      applyStimulus(2, 9'h041, 1'b0, 2'b10, -1);
      expectFrame("o72_41_stop2low", 2, 9'h041, 1'b0, 1'b1);

      $display("[TB] randomized frames");
      for (int k = 0; k < 3; k++) begin
         for (int n = 0; n < 4; n++) begin
            word    = 9'($urandom);
            flip    = (PMODE[k] != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            stopLow = 2'($urandom_range(0, 3));
            if (SBITS[k] == 1) stopLow[1] = 1'b0;
            applyStimulus(k, word, flip, stopLow, -1);
            expectFrame($sformatf("rand_dut%0d_%0d", k, n), k, word,
                        (PMODE[k] != 0) && flip, |stopLow);
         end
      end

      $display("[TB] false start glitch");
      sawBusy  = 1'b0;
      sawValid = 1'b0;
      rxLine[0] = 1'b0;
      repeat (4) @(negedge clock);
      rxLine[0] = 1'b1;
      for (int c = 0; c < CPB + 4; c++) begin
         if (busyV[0]) sawBusy = 1'b1;
         if (validV[0]) sawValid = 1'b1;
         @(negedge clock);
      end
      checkOutput("glitch_busy_seen", 16'(sawBusy), 16'd1);
      checkOutput("glitch_back_idle", 16'(busyV[0]), 16'd0);
      checkOutput("glitch_no_word", 16'({sawValid, capQ.size() != 0}), 16'd0);

      $display("[TB] line break");
      rxLine[0] = 1'b0;
      repeat (12 * CPB) @(negedge clock);
      rxLine[0] = 1'b1;
      repeat (2 * CPB) @(negedge clock);
      expectFrame("break", 0, 9'h000, 1'b0, 1'b1);
      repeat (2 * CPB) @(negedge clock);
      checkOutput("break_single_frame", 16'({busyV[0], capQ.size() != 0}), 16'd0);

      $display("[TB] overrun");
      readyV[0] = 1'b0;
      applyStimulus(0, 9'h011, 1'b0, 2'b00, -1);
      applyStimulus(0, 9'h022, 1'b0, 2'b00, -1);
      expectFrame("ovr_first", 0, 9'h011, 1'b0, 1'b0);
      checkOutput("ovr_held", 16'({validV[0], ovV[0], data0}), 16'({1'b1, 1'b1, 8'h11}));
      checkOutput("ovr_second_dropped", 16'(capQ.size()), 16'd0);
      readyV[0] = 1'b1;
      @(negedge clock);
      readyV[0] = 1'b0;
      checkOutput("ovr_cleared", 16'({validV[0], ovV[0]}), 16'd0);
      readyV[0] = 1'b1;

      $display("[TB] reset mid-frame");
      applyStimulus(1, 9'h0F0, 1'b0, 2'b00, 4);
      checkOutput("busy_mid_frame", 16'(busyV[1]), 16'd1);
      reset_n = 1'b0;
      @(negedge clock);
      for (int k = 0; k < 3; k++)
         checkOutput($sformatf("midreset_outputs_dut%0d", k), 16'(outputsOf(k)), 16'd0);
      rxLine = 3'b111;
      repeat (4) @(negedge clock);
      reset_n = 1'b1;
      repeat (4) @(negedge clock);
      applyStimulus(1, 9'h03C, 1'b0, 2'b00, -1);
      expectFrame("after_reset_3c", 1, 9'h03C, 1'b0, 1'b0);
      checkOutput("no_stray_words", 16'(capQ.size()), 16'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
